// File: rtl/sha1_pkg.sv
// Shared constants and FSM encoding for the SHA-1 message padder.
package sha1_pkg;

  localparam logic [31:0] SHA1_IV_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_IV_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_IV_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_IV_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_IV_H4 = 32'hC3D2E1F0;
  localparam logic [159:0] SHA1_IV = {SHA1_IV_H0, SHA1_IV_H1, SHA1_IV_H2, SHA1_IV_H3,
                                      SHA1_IV_H4};

  localparam int unsigned WORDS_PER_BLK = 16;
  // Word index of the upper half of the 64-bit length field.
  localparam int unsigned LEN_WORD_HI = 14;
  localparam logic [31:0] PAD_MARK = 32'h80000000;

  typedef enum logic [2:0] {
    StIdle,
    StMsg,
    StMark,
    StZero,
    StLenH,
    StLenL,
    StKick,
    StWait
  } state_t;

  // Successor of a padding load at block position pos: the length field follows position 13,
  // a padding load at position 15 ends a block that cannot hold the length.
  function automatic state_t pad_next_state(input logic [3:0] pos);
    state_t nxt;
    nxt = StZero;
    if (pos == 4'(LEN_WORD_HI - 1)) begin
      nxt = StLenH;
    end else if (pos == 4'(WORDS_PER_BLK - 1)) begin
      nxt = StKick;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sha1_pad_word.sv
// Builds the final message word: keeps the valid bytes, inserts the 0x80 marker in the first
// invalid byte and clears the rest. A full word (in_bytes = 0) passes through unchanged.
module sha1_pad_word (
  input  logic [31:0] in_data,
  input  logic [1:0]  in_bytes,
  output logic [31:0] pad_word
);

  // Byte-lane select for the marker position.
  always_comb begin
    pad_word = in_data;
    unique case (in_bytes)
      2'd1:    pad_word = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    pad_word = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    pad_word = {in_data[31:8], 8'h80};
      default: pad_word = in_data;
    endcase
  end

endmodule

// File: rtl/sha1_msg_pad.sv
// SHA-1 message padder: streams message words into the round core, appends the 0x80 marker,
// zero fill and 64-bit bit length, and sequences one 512-bit block per core run.
// Optional build macro SHA1_PAD_BLK_CNT_EN adds the blk_cnt output (blocks issued per message).
module sha1_msg_pad
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         in_ready,
  output logic [31:0]  core_din,
  output logic         core_load,
  output logic         core_start,
  output logic         core_use_prev_cv,
  output logic [159:0] core_cv,
  input  logic         core_ready,
`ifdef SHA1_PAD_BLK_CNT_EN
  output logic [15:0]  blk_cnt,
`endif
  output logic         msg_done
);

  localparam logic [3:0] IdxLast = 4'(WORDS_PER_BLK - 1);

  state_t state_q, state_d;

  logic [3:0]       word_idx_q;
  logic [LEN_W-1:0] bit_len_q;
  logic [LEN_W-1:0] len_inc;
  logic [63:0]      len64;
  logic             last_blk_q;   // current block carries the length field
  logic             len_only_q;   // next block is zero fill plus length
  logic             pend_mark_q;  // next block starts with the marker word
  logic             use_prev_q;

  logic        load_d, load_q;
  logic        start_d, start_q;
  logic        done_d, done_q;
  logic [31:0] din_d, din_q;
  logic [31:0] last_word;

  logic accept;
  logic pad_fill;

  assign accept = (state_q == StMsg) && in_valid;
  // This load places or follows the marker, so the block is in its padding phase.
  assign pad_fill = (state_q == StMark) || (state_q == StZero) ||
                    (accept && in_last && (in_bytes != 2'd0));

  sha1_pad_word u_pad_word (
    .in_data  (in_data),
    .in_bytes (in_bytes),
    .pad_word (last_word)
  );

  // Bit-length increment for the accepted word.
  always_comb begin
    len_inc = LEN_W'(32);
    if (in_last && (in_bytes != 2'd0)) begin
      len_inc = LEN_W'({in_bytes, 3'b000});
    end
  end

  // Zero-extend the length counter into the 64-bit length field.
  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bit_len_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StMsg;
      StMsg: begin
        if (in_valid) begin
          if (in_last && (in_bytes != 2'd0)) begin
            state_d = pad_next_state(word_idx_q);
          end else if (word_idx_q == IdxLast) begin
            state_d = StKick;
          end else if (in_last) begin
            state_d = StMark;
          end
        end
      end
      StMark, StZero: state_d = pad_next_state(word_idx_q);
      StLenH:         state_d = StLenL;
      StLenL:         state_d = StKick;
      StKick:         state_d = StWait;
      StWait: begin
        if (core_ready) begin
          if (last_blk_q)       state_d = StIdle;
          else if (len_only_q)  state_d = StZero;
          else if (pend_mark_q) state_d = StMark;
          else                  state_d = StMsg;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; core-facing outputs are registered below.
  always_comb begin
    in_ready = (state_q == StMsg);
    load_d   = 1'b0;
    din_d    = '0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StMsg: begin
        if (in_valid) begin
          load_d = 1'b1;
          din_d  = in_last ? last_word : in_data;
        end
      end
      StMark: begin
        load_d = 1'b1;
        din_d  = PAD_MARK;
      end
      StZero: load_d = 1'b1;
      StLenH: begin
        load_d = 1'b1;
        din_d  = len64[63:32];
      end
      StLenL: begin
        load_d = 1'b1;
        din_d  = len64[31:0];
      end
      StKick:  start_d = 1'b1;
      StWait:  done_d  = core_ready && last_blk_q;
      default: ;
    endcase
  end

  // Word counter, length accumulator, block flags and registered core outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx_q  <= '0;
      bit_len_q   <= '0;
      last_blk_q  <= 1'b0;
      len_only_q  <= 1'b0;
      pend_mark_q <= 1'b0;
      use_prev_q  <= 1'b0;
      load_q      <= 1'b0;
      din_q       <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      load_q  <= load_d;
      din_q   <= din_d;
      start_q <= start_d;
      done_q  <= done_d;
      if ((state_q == StIdle) && in_valid) begin
        word_idx_q  <= '0;
        bit_len_q   <= '0;
        last_blk_q  <= 1'b0;
        len_only_q  <= 1'b0;
        pend_mark_q <= 1'b0;
        use_prev_q  <= 1'b0;
      end
      if (load_d) begin
        word_idx_q <= word_idx_q + 4'd1;
      end
      if (accept) begin
        bit_len_q <= bit_len_q + len_inc;
      end
      if (pad_fill && (word_idx_q == IdxLast)) begin
        len_only_q <= 1'b1;
      end
      if (accept && in_last && (in_bytes == 2'd0) && (word_idx_q == IdxLast)) begin
        pend_mark_q <= 1'b1;
      end
      if (state_q == StLenL) begin
        last_blk_q <= 1'b1;
      end
      if ((state_q == StWait) && core_ready) begin
        use_prev_q  <= !last_blk_q;
        len_only_q  <= 1'b0;
        pend_mark_q <= 1'b0;
      end
    end
  end

`ifdef SHA1_PAD_BLK_CNT_EN
  logic [15:0] blk_cnt_q;

  // Blocks issued for the current message; holds after completion until the next message.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
    end else if ((state_q == StIdle) && in_valid) begin
      blk_cnt_q <= '0;
    end else if (state_q == StKick) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

  assign core_din         = din_q;
  assign core_load        = load_q;
  assign core_start       = start_q;
  assign core_use_prev_cv = use_prev_q;
  assign core_cv          = SHA1_IV;
  assign msg_done         = done_q;

endmodule

// File: tb/tb_sha1_msg_pad.sv
// Scoreboard bench for sha1_msg_pad with a behavioural SHA-1 core model.
`timescale 1ns/1ps
module tb_sha1_msg_pad;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [1:0]   in_bytes = '0;
  logic         in_ready;
  logic [31:0]  core_din;
  logic         core_load;
  logic         core_start;
  logic         core_use_prev_cv;
  logic [159:0] core_cv;
  logic         core_ready = 1'b0;
  logic         msg_done;
`ifdef SHA1_PAD_BLK_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  localparam logic [159:0] IV     = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] DG_ABC = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
  localparam logic [159:0] DG_56  = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;

  // "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"
  logic [31:0] msg56 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                              32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                              32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                              32'h6D6E6F70, 32'h6E6F7071};

  always #5 clk = ~clk;

  sha1_msg_pad dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_bytes         (in_bytes),
    .in_ready         (in_ready),
    .core_din         (core_din),
    .core_load        (core_load),
    .core_start       (core_start),
    .core_use_prev_cv (core_use_prev_cv),
    .core_cv          (core_cv),
    .core_ready       (core_ready),
`ifdef SHA1_PAD_BLK_CNT_EN
    .blk_cnt          (blk_cnt),
`endif
    .msg_done         (msg_done)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_words [$];
  bit           exp_prev [$];
  bit           exp_dchk [$];
  logic [159:0] exp_dig [$];
  int           exp_blk [$];

  logic [31:0]  wbuf [16];
  int           nload = 0;
  bit           busy = 1'b0;
  int           lat = 0;
  logic [159:0] digest = '0;
  logic [159:0] pend_cv = '0;
  int           start_cnt = 0;
  int           done_cnt = 0;
  int           load_seen = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [159:0] sha1_comp(input logic [159:0] cv, input logic [31:0] blk [16]);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = cv;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d);
        k = 32'h5A827999;
      end else if (i < 40) begin
        f = b ^ c ^ d;
        k = 32'h6ED9EBA1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d);
        k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;
        k = 32'hCA62C1D6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d;
      d = c;
      c = {b[1:0], b[31:2]};
      b = a;
      a = t;
    end
    return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
  endfunction

  // Core model: captures loaded words, computes the block on start, pulses ready 83 cycles on.
  always @(negedge clk) begin
    core_ready = 1'b0;
    if (reset) begin
      nload = 0;
      busy  = 1'b0;
      lat   = 0;
    end else begin
      if (busy) begin
        lat--;
        if (lat == 0) begin
          busy       = 1'b0;
          digest     = pend_cv;
          core_ready = 1'b1;
        end
      end
      if (core_load) begin
        if (nload < 16) wbuf[nload] = core_din;
        nload++;
      end
      if (core_start) begin
        chk("loads_per_block", 160'(nload), 160'd16);
        chk("start_while_busy", 160'(busy), 160'd0);
        chk("core_cv", core_cv, IV);
        if (exp_prev.size() == 0) chk("unexpected_start", 160'd1, 160'd0);
        else chk("use_prev_cv", 160'(core_use_prev_cv), 160'(exp_prev.pop_front()));
        pend_cv = sha1_comp(core_use_prev_cv ? digest : core_cv, wbuf);
        busy = 1'b1;
        lat  = 83;
        nload = 0;
        start_cnt++;
      end
    end
  end

  // Load monitor: every core_load must match the next expected padded word.
  always @(negedge clk) begin
    if (!reset && core_load) begin
      if (exp_words.size() == 0) chk("unexpected_load", 160'(core_din), 160'hDEAD);
      else chk($sformatf("load_word[%0d]", load_seen), 160'(core_din), 160'(exp_words.pop_front()));
      load_seen++;
    end
  end

  // Completion monitor: digest and block count at msg_done.
  always @(negedge clk) begin
    if (!reset && msg_done) begin
      done_cnt++;
      if (exp_dchk.size() == 0) begin
        chk("unexpected_msg_done", 160'd1, 160'd0);
      end else begin
        if (exp_dchk.pop_front()) chk("digest", digest, exp_dig.pop_front());
        else void'(exp_dig.pop_front());
`ifdef SHA1_PAD_BLK_CNT_EN
        chk("blk_cnt_at_done", 160'(blk_cnt), 160'(exp_blk.pop_front()));
`endif
      end
    end
  end

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) exp_words.push_back(32'h0);
  endtask

  task automatic expect_msg(input bit dchk, input logic [159:0] dg, input int nblk);
    exp_dchk.push_back(dchk);
    exp_dig.push_back(dg);
    exp_blk.push_back(nblk);
    exp_prev.push_back(1'b0);
    for (int i = 1; i < nblk; i++) exp_prev.push_back(1'b1);
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb,
                           input bit gap);
    int t;
    t = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 160'd0, 160'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < n) chk("msg_done_timeout", 160'(done_cnt), 160'(n));
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 160'(in_ready), 160'd0);
    chk({tag, "_core_load"}, 160'(core_load), 160'd0);
    chk({tag, "_core_start"}, 160'(core_start), 160'd0);
    chk({tag, "_use_prev_cv"}, 160'(core_use_prev_cv), 160'd0);
    chk({tag, "_core_din"}, 160'(core_din), 160'd0);
    chk({tag, "_msg_done"}, 160'(msg_done), 160'd0);
  endtask

  task automatic push_abc();
    exp_words.push_back(32'h61626380);
    push_zeros(14);
    exp_words.push_back(32'h00000018);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // "abc": trailing byte of the input word must be overwritten by the marker
    push_abc();
    expect_msg(1'b1, DG_ABC, 1);
    send_word(32'h616263FF, 1'b1, 2'd3, 1'b0);
    wait_done(1);

    // "abcd": full last word, marker gets a word of its own
    exp_words.push_back(32'h61626364);
    exp_words.push_back(32'h80000000);
    push_zeros(13);
    exp_words.push_back(32'h00000020);
    expect_msg(1'b0, '0, 1);
    send_word(32'h61626364, 1'b1, 2'd0, 1'b0);
    wait_done(2);

    // 56 bytes with in_valid toggling: marker in word 14, length in a second block
    for (int i = 0; i < 14; i++) exp_words.push_back(msg56[i]);
    exp_words.push_back(32'h80000000);
    push_zeros(16);
    exp_words.push_back(32'h000001C0);
    expect_msg(1'b1, DG_56, 2);
    for (int i = 0; i < 14; i++) send_word(msg56[i], i == 13, 2'd0, 1'b1);
    wait_done(3);

    // 55 bytes: marker in the last byte of word 13, single block
    for (int i = 0; i < 13; i++) exp_words.push_back(msg56[i]);
    exp_words.push_back(32'h6E6F7080);
    exp_words.push_back(32'h00000000);
    exp_words.push_back(32'h000001B8);
    expect_msg(1'b0, '0, 1);
    for (int i = 0; i < 13; i++) send_word(msg56[i], 1'b0, 2'd0, 1'b0);
    send_word(32'h6E6F7071, 1'b1, 2'd3, 1'b0);
    wait_done(4);

    // 64 bytes: block fills exactly, marker opens the second block
    for (int i = 0; i < 16; i++) exp_words.push_back(32'hC0DE0000 + i);
    exp_words.push_back(32'h80000000);
    push_zeros(14);
    exp_words.push_back(32'h00000200);
    expect_msg(1'b0, '0, 2);
    for (int i = 0; i < 16; i++) send_word(32'hC0DE0000 + i, i == 15, 2'd0, 1'b0);
    wait_done(5);

    // 120 bytes: three blocks
    for (int i = 0; i < 30; i++) exp_words.push_back(32'h5A000000 + i);
    exp_words.push_back(32'h80000000);
    push_zeros(16);
    exp_words.push_back(32'h000003C0);
    expect_msg(1'b0, '0, 3);
    for (int i = 0; i < 30; i++) send_word(32'h5A000000 + i, i == 29, 2'd0, 1'b0);
    wait_done(6);
`ifdef SHA1_PAD_BLK_CNT_EN
    repeat (5) @(negedge clk);
    chk("blk_cnt_hold", 160'(blk_cnt), 160'd3);
`endif

    // Reset in the middle of WAIT aborts the message
    push_abc();
    expect_msg(1'b1, DG_ABC, 1);
    t = start_cnt;
    send_word(32'h61626300, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 200 && start_cnt == t; i++) @(negedge clk);
    chk("start_before_reset", 160'(start_cnt), 160'(t + 1));
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_words.delete();
    exp_prev.delete();
    exp_dchk.delete();
    exp_dig.delete();
    exp_blk.delete();
    chk_idle_outputs("midwait_reset");
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_done_after_abort", 160'(done_cnt), 160'd6);

    // Fresh "abc" after the abort
    push_abc();
    expect_msg(1'b1, DG_ABC, 1);
    send_word(32'h61626300, 1'b1, 2'd3, 1'b0);
    wait_done(7);

    chk("words_left", 160'(exp_words.size()), 160'd0);
    chk("starts_left", 160'(exp_prev.size()), 160'd0);
    chk("dones_left", 160'(exp_dchk.size()), 160'd0);
    chk("msg_done_count", 160'(done_cnt), 160'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha1_msg_pad.md
Name: sha1_msg_pad

Overview:
- Upstream feeder for the SHA-1 round core.
- Accepts a big-endian message stream of 32-bit words with valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit bit-length.
- Drives the core's word-load, start, chaining-select and initial-CV inputs one 512-bit block at a time, waiting for core completion between blocks.

Parameters:
- LEN_W, 64, width of the message bit-length counter. Allowed range 35..64; bits above LEN_W in the length field are zero.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- in_data  in  32  message word, byte 0 in bits [31:24]
- in_valid  in  1  in_data valid
- in_last  in  1  final word of the message; qualified by in_valid
- in_bytes  in  2  valid bytes in the final word: 0 means 4, otherwise 1..3; ignored unless in_last
- in_ready  out  1  word accepted when in_valid and in_ready are both 1
- core_din  out  32  word to core din
- core_load  out  1  shift core_din into the core W register
- core_start  out  1  single-cycle start pulse to the core
- core_use_prev_cv  out  1  chain from the previous block digest
- core_cv  out  160  constant IV 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0
- core_ready  in  1  core done pulse; digest valid on core cv_next
- msg_done  out  1  one-cycle pulse on core_ready of the final block

Behaviour:
- Reset values: in_ready=0, core_load=0, core_start=0, core_use_prev_cv=0, core_din=0, msg_done=0. Internal counters and FSM clear to IDLE.
- Reset at any cycle aborts the message. The core is reset by the same signal.
- States:
  - IDLE: wait for in_valid; go to MSG. The first accepted word clears bit_len and word_idx.
  - MSG: in_ready=1. Each accepted word → core_din=in_data, core_load=1, word_idx+1, bit_len += 32, or 8*in_bytes on the last word.
    - Last word with in_bytes 1..3: the 0x80 marker replaces the first invalid byte; bytes after it are forced to 0. Go to ZERO.
    - Last word with in_bytes=0: go to MARK.
    - word_idx wrapping 15→0: go to KICK with in_ready=0.
  - MARK: load 0x80000000, then go to ZERO.
  - ZERO: load 0 until word_idx=14, then LENH. If the marker landed in word 14 or 15, load zeros to word 15, KICK, and mark the next block length-only.
  - LENH: load bit_len[63:32]. LENL: load bit_len[31:0]. Both go to KICK with the final flag set.
  - KICK: core_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold all outputs idle until core_ready. Then:
    - final block → msg_done=1 and go to IDLE;
    - length-only block → ZERO;
    - otherwise → MSG.
- Exactly 16 core_load cycles occur between consecutive core_start pulses. core_start is never asserted while the core is computing. Core latency is 83 cycles from start to core_ready.
- core_use_prev_cv=0 from message start through the first block's core_start. It is 1 from the first WAIT exit until IDLE.
- in_ready drops during KICK/WAIT/pad states. A stalled in_valid produces no load.
- bit_len wraps modulo 2^LEN_W; there is no error flag.

Optional Feature:
- SHA1_PAD_BLK_CNT_EN defined:
  - Adds output blk_cnt[15:0], the count of blocks issued for the current message.
  - Increments on each core_start; cleared on reset and on the first word of a message.
  - Holds its value after msg_done.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sha1_pkg holds:
  - SHA-1 IV constants;
  - WORDS_PER_BLK=16;
  - LEN_WORD_HI=14;
  - PAD_MARK=32'h80000000;
  - the FSM state encoding.
- One natural sub-module, sha1_pad_word: combinational, takes in_data/in_bytes and produces the marker-inserted, masked last word.

Test Plan:
- "abc" (1 word, in_bytes=3) → loads 61626380, 13×0, 00000000, 00000018. One start; digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D; msg_done once.
- Empty message (single word, in_last, in_bytes=1 with data treated as marker position 0 disallowed; use dedicated zero-length via in_last with in_bytes=0 after no data is illegal) → instead, 4-byte "abcd" in_bytes=0 → MARK word 80000000, length 00000020.
- 56-byte message (14 words, last full) → two blocks. Block 1 word14=80000000, word15=0. Block 2 is 14 zeros, 00000000, 000001C0. use_prev_cv=1 on block 2.
- 55-byte message → single block, word13=xxxxxx80, length 000001B8.
- in_valid toggled every other cycle plus reset asserted mid-WAIT → no spurious loads. After reset all outputs are 0, and a new "abc" gives the correct digest.
- SHA1_PAD_BLK_CNT_EN: 120-byte message → blk_cnt ends at 3.
